// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: read-side pointer controller for the dual-clock FIFO.
// Wrap-extended bin/gray read pointer, write-pointer synchroniser, flags.
//
// Ports:
//   rd_clock     read-domain clock, rising edge
//   reset_n      asynchronous active-low reset
//   rd_en        consumer read request
//   wr_gray      write pointer (gray, write domain, asynchronous)
//   rd_addr      RAM read address
//   rd_gray      registered gray read pointer, to the write domain
//   rd_ack       read accepted this cycle (rd_en & ~empty)
//   empty        FIFO empty, registered
//   almost_empty level <= ae_thresh, registered (equals empty if level off)
//   underflow    sticky: read attempted while empty
//   rd_level     words available (zero unless FIFO_RD_LEVEL_EN)
//
// Optional feature macro: FIFO_RD_LEVEL_EN (gray-to-binary + level logic).

module fifo_rd_ptr_ctrl #(
  parameter int addr_width  = 4,
  parameter int sync_stages = 2,
  parameter int ae_thresh   = 2
) (
  input  logic                  rd_clock,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [addr_width:0]   wr_gray,
  output logic [addr_width-1:0] rd_addr,
  output logic [addr_width:0]   rd_gray,
  output logic                  rd_ack,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [addr_width:0]   rd_level
);

  localparam int PW = addr_width + 1;

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_gray;
  logic [PW-1:0] r_sync [sync_stages];
  logic          r_empty;
  logic          r_uf;

  logic          w_ack;
  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_wr_gray_s;

  assign w_ack          = rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + {{addr_width{1'b0}}, w_ack};
  assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
  assign w_wr_gray_s    = r_sync[sync_stages-1];

  always_ff @(posedge rd_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bin  <= '0;
      r_rd_gray <= '0;
      r_empty   <= 1'b1;
      r_uf      <= 1'b0;
      for (int i = 0; i < sync_stages; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_rd_bin  <= w_rd_bin_next;
      r_rd_gray <= w_rd_gray_next;
      // Compare against the synchronised write pointer as it stands now;
      // a write is only seen once it has left the last sync flop.
      r_empty   <= (w_rd_gray_next == w_wr_gray_s);
      r_uf      <= r_uf | (rd_en & r_empty);
      r_sync[0] <= wr_gray;
      for (int i = 1; i < sync_stages; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [PW-1:0] AE_T = PW'(ae_thresh);

  logic [PW-1:0] w_wr_bin_s;
  logic [PW-1:0] w_diff;
  logic [PW-1:0] r_level;
  logic          r_ae;

  // Prefix XOR from the MSB down.
  always_comb begin
    w_wr_bin_s = '0;
    w_wr_bin_s[PW-1] = w_wr_gray_s[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      w_wr_bin_s[i] = w_wr_bin_s[i+1] ^ w_wr_gray_s[i];
    end
  end

  // Modulo subtraction; the wrap bit makes a full FIFO read 2^addr_width.
  assign w_diff = w_wr_bin_s - w_rd_bin_next;

  always_ff @(posedge rd_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_ae    <= 1'b1;
    end else begin
      r_level <= w_diff;
      r_ae    <= (w_diff <= AE_T);
    end
  end

  assign rd_level     = r_level;
  assign almost_empty = r_ae;
`else
  assign rd_level     = '0;
  assign almost_empty = r_empty;
`endif

  assign rd_addr   = r_rd_bin[addr_width-1:0];
  assign rd_gray   = r_rd_gray;
  assign rd_ack    = w_ack;
  assign empty     = r_empty;
  assign underflow = r_uf;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// tb_fifo_rd_ptr_ctrl: directed bench for the FIFO read pointer controller.
// Counter-level model plus hand-computed literal checks.

module tb_fifo_rd_ptr_ctrl;

  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int TH   = 2;
  localparam int MSK  = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en = 1'b0;
  logic [AW:0]   wr_gray = '0;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_gray;
  logic          rd_ack;
  logic          empty;
  logic          almost_empty;
  logic          underflow;
  logic [AW:0]   rd_level;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;

  fifo_rd_ptr_ctrl #(
    .addr_width (AW),
    .sync_stages(SYNC),
    .ae_thresh  (TH)
  ) dut (
    .rd_clock    (clk),
    .reset_n     (reset_n),
    .rd_en       (rd_en),
    .wr_gray     (wr_gray),
    .rd_addr     (rd_addr),
    .rd_gray     (rd_gray),
    .rd_ack      (rd_ack),
    .empty       (empty),
    .almost_empty(almost_empty),
    .underflow   (underflow),
    .rd_level    (rd_level)
  );

  always #5 clk = ~clk;

  // Model: count of words read and a history of write counts.
  int m_rd = 0;
  int m_empty = 1;
  int m_level = 0;
  int m_uf = 0;
  int m_hist [SYNC] = '{default: 0};
  int m_ack;
  int m_nxt;
  int m_ws;

  always_comb begin
    m_ack = (rd_en === 1'b1 && m_empty == 0) ? 1 : 0;
    m_nxt = (m_rd + m_ack) & MSK;
    m_ws  = m_hist[SYNC-1];
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rd    <= 0;
      m_empty <= 1;
      m_level <= 0;
      m_uf    <= 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] <= 0;
    end else begin
      m_rd    <= m_nxt;
      m_empty <= (m_nxt == m_ws) ? 1 : 0;
      m_level <= (m_ws - m_nxt) & MSK;
      if (rd_en === 1'b1 && m_empty == 1) m_uf <= 1;
      m_hist[0] <= wr_cnt;
      for (int i = 1; i < SYNC; i++) m_hist[i] <= m_hist[i-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1) begin
        int lv;
        int ae;
`ifdef FIFO_RD_LEVEL_EN
        lv = m_level;
        ae = (m_level <= TH) ? 1 : 0;
`else
        lv = 0;
        ae = m_empty;
`endif
        chk("m_addr", 32'(rd_addr), 32'(m_rd % (1 << AW)));
        chk("m_gray", 32'(rd_gray), 32'(m_rd ^ (m_rd >> 1)));
        chk("m_ack", 32'(rd_ack), 32'(m_ack));
        chk("m_empty", 32'(empty), 32'(m_empty));
        chk("m_ae", 32'(almost_empty), 32'(ae));
        chk("m_uf", 32'(underflow), 32'(m_uf));
        chk("m_level", 32'(rd_level), 32'(lv));
      end
    end
  end

  task automatic setwr(input int n);
    wr_cnt  = n & MSK;
    wr_gray = (AW+1)'(wr_cnt ^ (wr_cnt >> 1));
  endtask

  task automatic tick(input logic en);
    @(negedge clk);
    #1 rd_en = en;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    rd_en = 1'b0;
    setwr(0);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_gray", 32'(rd_gray), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_level", 32'(rd_level), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset();

    // Empty gate: reads refused, underflow sticks.
    tick(1'b1);
    chk("gate_ack", 32'(rd_ack), 0);
    chk("gate_addr", 32'(rd_addr), 0);
    tick(1'b1);
    chk("gate_uf", 32'(underflow), 1);
    tick(1'b1);
    chk("gate_addr2", 32'(rd_addr), 0);
    tick(1'b0);
    chk("gate_uf2", 32'(underflow), 1);

    // Sync latency: gray(5)=00111 visible after the 3rd edge.
    do_reset();
    setwr(5);
    chk("gray5", 32'(wr_gray), 32'h07);
    tick(1'b0);
    chk("lat_e1", 32'(empty), 1);
    tick(1'b0);
    chk("lat_e2", 32'(empty), 1);
    tick(1'b0);
    chk("lat_e3", 32'(empty), 0);
`ifdef FIFO_RD_LEVEL_EN
    chk("lat_lvl", 32'(rd_level), 5);
    chk("lat_ae", 32'(almost_empty), 0);
`endif

    // Drain five words.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      chk("drain_addr", 32'(rd_addr), 32'(i));
      chk("drain_ack", 32'(rd_ack), 1);
`ifdef FIFO_RD_LEVEL_EN
      chk("drain_ae", 32'(almost_empty), (i >= 3) ? 1 : 0);
`endif
    end
    tick(1'b1);
    chk("drain_e", 32'(empty), 1);
    chk("drain_ack6", 32'(rd_ack), 0);
    tick(1'b0);

    // Full depth, then wrap of the read pointer.
    do_reset();
    setwr(16);
    chk("gray16", 32'(wr_gray), 32'h18);
    repeat (3) tick(1'b0);
    chk("full_e", 32'(empty), 0);
`ifdef FIFO_RD_LEVEL_EN
    chk("full_lvl", 32'(rd_level), 16);
`endif
    repeat (16) tick(1'b1);
    tick(1'b0);
    chk("full_gray", 32'(rd_gray), 32'h18);
    chk("full_e2", 32'(empty), 1);
    setwr(32);
    repeat (3) tick(1'b0);
    chk("wrap_e", 32'(empty), 0);
    repeat (15) tick(1'b1);
    tick(1'b0);
    chk("wrap_g31", 32'(rd_gray), 32'h10);
    tick(1'b1);
    tick(1'b0);
    chk("wrap_g0", 32'(rd_gray), 0);
    chk("wrap_addr", 32'(rd_addr), 0);
    chk("wrap_e2", 32'(empty), 1);

    // Asynchronous reset between edges.
    do_reset();
    setwr(7);
    repeat (3) tick(1'b0);
    chk("mid_e", 32'(empty), 0);
`ifdef FIFO_RD_LEVEL_EN
    chk("mid_lvl", 32'(rd_level), 7);
`endif
    tick(1'b1);
    tick(1'b1);
    rd_en = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    setwr(0);
    #1;
    chk("arst_e", 32'(empty), 1);
    chk("arst_ae", 32'(almost_empty), 1);
    chk("arst_gray", 32'(rd_gray), 0);
    chk("arst_addr", 32'(rd_addr), 0);
    chk("arst_uf", 32'(underflow), 0);
    chk("arst_lvl", 32'(rd_level), 0);
    #1 reset_n = 1'b1;
    repeat (2) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
# fifo_rd_ptr_ctrl

Read-side pointer controller for the asynchronous dual-clock FIFO, successor to the plain gray-counter read controller. It adds:
- a wrap-extended binary/gray read pointer;
- a synchroniser for the write-domain gray pointer;
- registered empty and almost-empty flags;
- a sticky underflow flag;
- an optional fill-level output.

It sits in the read clock domain between the FIFO RAM read port and the consumer. Its gray pointer output feeds the write-side controller's synchroniser.

## Interface

Parameters:
- addr_width, 4: RAM address bits; FIFO depth = 2^addr_width.
- sync_stages, 2: flops in the write-pointer synchroniser; legal values 2 and 3.
- ae_thresh, 2: almost_empty asserts when level ≤ ae_thresh; range 0 to 2^addr_width − 1.

Ports:
- rd_clock, input, 1: read-domain clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- rd_en, input, 1: consumer read request.
- wr_gray, input, addr_width+1: write pointer, gray coded, from the write domain (asynchronous).
- rd_addr, output, addr_width: RAM read address.
- rd_gray, output, addr_width+1: registered gray read pointer, to the write domain.
- rd_ack, output, 1: read accepted this cycle (combinational, rd_en & ~empty).
- empty, output, 1: FIFO empty, registered.
- almost_empty, output, 1: level ≤ ae_thresh, registered.
- underflow, output, 1: sticky; read attempted while empty.
- rd_level, output, addr_width+1: words available (FIFO_RD_LEVEL_EN only).

## Operation

Reset values:
- All pointer, synchroniser and flag registers clear: rd_bin = 0, rd_gray = 0, sync chain = 0, rd_level = 0, underflow = 0.
- empty = 1 and almost_empty = 1.

Read pointer:
- rd_bin is addr_width+1 bits and carries a wrap bit.
- rd_bin_next = rd_bin + rd_ack, modulo 2^(addr_width+1).
- rd_addr = rd_bin[addr_width−1:0].
- rd_gray = rd_bin ^ (rd_bin >> 1), registered from rd_bin_next.

Handshake:
- A read is accepted only when rd_en=1 and empty=0.
- rd_ack is high in the cycle of acceptance, and rd_addr in that cycle addresses the word being consumed.
- rd_en=1 while empty=1 has no pointer effect and sets underflow. underflow stays set until reset.

Synchroniser:
- wr_gray passes through sync_stages flops to give wr_gray_s.
- wr_bin_s is the gray-to-binary conversion of wr_gray_s (prefix XOR from the MSB down).

Flags:
- empty ← (gray of rd_bin_next == wr_gray_s).
- Pessimistic by construction: a write becomes visible only after synchronisation, so empty never deasserts early.
- Full-depth case: MSBs differ and the remaining bits are equal. This is not empty, and the level is 2^addr_width.

Level (FIFO_RD_LEVEL_EN):
- rd_level ← wr_bin_s − rd_bin_next, width addr_width+1, modulo arithmetic.
- almost_empty ← (wr_bin_s − rd_bin_next) ≤ ae_thresh.

Simultaneous events:
- A read of the last word in the same cycle the synchroniser delivers a new write: empty is computed from both updated values in that one evaluation.
- Pointer wrap from 2^(addr_width+1)−1 to 0 is seamless. The gray code changes one bit.

Reset mid-operation:
- Asserting reset_n low clears all state immediately, without a clock edge.
- The write side must be reset concurrently.

## Timing

- rd_ack: combinational; 0 cycles after rd_en.
- rd_addr, rd_gray: advance at the edge after an accepted read.
- A write pointer change on wr_gray becomes visible in empty, almost_empty and rd_level after sync_stages+1 rd_clock edges.
- Back-to-back reads at one word per cycle are supported while empty=0.

## Configuration

Macro FIFO_RD_LEVEL_EN.

Defined:
- The gray-to-binary converter and the subtractor are present.
- rd_level and almost_empty behave as in Operation.

Undefined:
- Converter and subtractor are omitted.
- rd_level is tied to 0.
- almost_empty is driven equal to empty.

## Test plan

1. **Reset:** reset_n low.
   - empty=1, almost_empty=1, rd_gray=0, rd_addr=0, underflow=0, rd_level=0.
2. **Empty gate:** wr_gray held at 0, rd_en=1 for 3 cycles.
   - rd_ack=0 throughout, rd_addr stays 0, underflow=1 and stays 1.
3. **Sync latency:** sync_stages=2, wr_gray set to gray(5)=00111.
   - empty falls at the 3rd edge, rd_level=5, almost_empty=0 (ae_thresh=2).
4. **Drain:** from scenario 3, rd_en=1 for 5 cycles.
   - rd_addr sequence 0,1,2,3,4.
   - almost_empty rises when rd_level reaches 2.
   - empty rises after the 5th accepted read; 6th request gives rd_ack=0.
5. **Full and wrap:**
   - wr_gray = gray(16) = 11000 (addr_width=4) → rd_level=16, empty=0.
   - 16 reads → rd_gray=11000, empty=1.
   - Continue to rd_bin 31→0: check rd_gray goes 10000→00000.
6. **Async reset mid-stream:** reset_n pulsed low between clock edges with rd_level=7.
   - All outputs return to reset values before the next rd_clock edge.
